// File: rtl/iir_pkg.sv
// Shared definitions for the IIR datapath: sample width default and sample type.
package iir_pkg;

   localparam int DEF_DATA_W = 4;

   typedef logic signed [DEF_DATA_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; head is the oldest entry, count is registered.
module sample_fifo
   import iir_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [DATA_W-1:0]          head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok, pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // pointers wrap for free since DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/iir_sample_feeder.sv
// Feeds buffered samples to the IIR filter at a fixed cadence and applies
// coefficient updates only on sample boundaries.
module iir_sample_feeder
   import iir_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH      = 4,
   parameter int SAMPLE_DIV = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          coef_in,
   input  logic                       coef_load,
   input  logic                       clr_underrun,
   output logic [DATA_W-1:0]          x_out,
   output logic [DATA_W-1:0]          a_out,
   output logic                       x_strobe,
   output logic                       underrun,
   output logic [$clog2(DEPTH+1)-1:0] fill_level
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV-1);

   logic [DIV_W-1:0]  div_q, div_d;
   logic [DATA_W-1:0] x_out_q, x_out_d;
   logic [DATA_W-1:0] a_out_q, a_out_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic              pending_q, pending_d;
   logic              x_strobe_q, x_strobe_d;
   logic              underrun_q, underrun_d;
   logic              tick, full, empty, push, pop;
   logic [DATA_W-1:0] head;

   assign tick     = (div_q == DIV_LAST);
   assign push     = in_valid && !full;
   assign pop      = tick && !empty;
   assign in_ready = !full;

   sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (in_data),
      .pop     (pop),
      .full    (full),
      .empty   (empty),
      .count   (fill_level),
      .head    (head)
   );

   // an empty tick still strobes a zero so the filter keeps its cadence
   always_comb begin
      div_d      = tick ? '0 : div_q + DIV_W'(1);
      x_strobe_d = tick;
      x_out_d    = x_out_q;
      underrun_d = underrun_q;
      if (tick) x_out_d = empty ? '0 : head;
      if (tick && empty)  underrun_d = 1'b1;
      else if (clr_underrun) underrun_d = 1'b0;
   end

   // a load on a tick cycle lands in the shadow after this tick consumed the old one
   always_comb begin
      a_out_d   = a_out_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (tick && pending_q) begin
         a_out_d   = shadow_q;
         pending_d = 1'b0;
      end
      if (coef_load) begin
         shadow_d  = coef_in;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q      <= '0;
         x_out_q    <= '0;
         a_out_q    <= '0;
         shadow_q   <= '0;
         pending_q  <= 1'b0;
         x_strobe_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         x_out_q    <= x_out_d;
         a_out_q    <= a_out_d;
         shadow_q   <= shadow_d;
         pending_q  <= pending_d;
         x_strobe_q <= x_strobe_d;
         underrun_q <= underrun_d;
      end
   end

   assign x_out    = x_out_q;
   assign a_out    = a_out_q;
   assign x_strobe = x_strobe_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_iir_sample_feeder.sv
// Drives a SAMPLE_DIV=4 and a SAMPLE_DIV=1 feeder with shared stimulus and
// checks both against a queue-level model of the feeder.
module tb_iir_sample_feeder;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic [3:0] in_data;
   logic       in_valid;
   logic [3:0] coef_in;
   logic       coef_load;
   logic       clr_underrun;

   logic       in_ready_w [2];
   logic [3:0] x_out_w    [2];
   logic [3:0] a_out_w    [2];
   logic       x_strobe_w [2];
   logic       underrun_w [2];
   logic [2:0] fill_w     [2];

   iir_sample_feeder #(.DATA_W(4), .DEPTH(DEPTH), .SAMPLE_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_w[0]), .coef_in(coef_in), .coef_load(coef_load),
      .clr_underrun(clr_underrun), .x_out(x_out_w[0]), .a_out(a_out_w[0]),
      .x_strobe(x_strobe_w[0]), .underrun(underrun_w[0]), .fill_level(fill_w[0])
   );

   iir_sample_feeder #(.DATA_W(4), .DEPTH(DEPTH), .SAMPLE_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_w[1]), .coef_in(coef_in), .coef_load(coef_load),
      .clr_underrun(clr_underrun), .x_out(x_out_w[1]), .a_out(a_out_w[1]),
      .x_strobe(x_strobe_w[1]), .underrun(underrun_w[1]), .fill_level(fill_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // model state per instance: queue contents kept oldest-first
   int mq    [2][8];
   int mcnt  [2];
   int mph   [2];
   int mdiv  [2];
   int mx    [2];
   int ma    [2];
   int mstb  [2];
   int mund  [2];
   int msh   [2];
   int mpend [2];
   int macc  [2];

   int ecnt;
   int log0 [64];
   int log1 [64];
   int nlog0, nlog1;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   function automatic int sx4(input logic [3:0] v);
      return int'($signed(v));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mcnt[i] = 0; mph[i] = 0; mx[i] = 0; ma[i] = 0; mstb[i] = 0;
         mund[i] = 0; msh[i] = 0; mpend[i] = 0; macc[i] = 0;
      end
      ecnt = 0; nlog0 = 0; nlog1 = 0;
   endtask

   task automatic model_step(input int i, input int v, input int d, input int cl,
                             input int cf, input int clr);
      bit tick, emp;
      tick = (mph[i] == mdiv[i] - 1);
      emp  = (mcnt[i] == 0);
      macc[i] = (v != 0 && mcnt[i] < DEPTH) ? 1 : 0;
      mstb[i] = tick ? 1 : 0;
      if (tick) begin
         if (emp) mx[i] = 0;
         else begin
            mx[i] = mq[i][0];
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
            mcnt[i]--;
         end
      end
      if (tick && emp) mund[i] = 1;
      else if (clr != 0) mund[i] = 0;
      if (macc[i] != 0) begin
         mq[i][mcnt[i]] = d;
         mcnt[i]++;
      end
      if (tick && mpend[i] != 0) begin
         ma[i] = msh[i];
         mpend[i] = 0;
      end
      if (cl != 0) begin
         msh[i] = cf;
         mpend[i] = 1;
      end
      mph[i] = (mph[i] + 1) % mdiv[i];
   endtask

   task automatic cyc(input logic v, input logic [3:0] d, input logic cl,
                      input logic [3:0] cf, input logic clr);
      in_valid = v; in_data = d; coef_load = cl; coef_in = cf; clr_underrun = clr;
      for (int i = 0; i < 2; i++) model_step(i, int'(v), sx4(d), int'(cl), sx4(cf), int'(clr));
      @(posedge clk);
      #1;
      ecnt++;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("x_out[%0d]", i),    sx4(x_out_w[i]),    mx[i]);
         chk($sformatf("a_out[%0d]", i),    sx4(a_out_w[i]),    ma[i]);
         chk($sformatf("x_strobe[%0d]", i), int'(x_strobe_w[i]), mstb[i]);
         chk($sformatf("underrun[%0d]", i), int'(underrun_w[i]), mund[i]);
         chk($sformatf("fill[%0d]", i),     int'(fill_w[i]),    mcnt[i]);
         chk($sformatf("in_ready[%0d]", i), int'(in_ready_w[i]), (mcnt[i] < DEPTH) ? 1 : 0);
      end
      if (x_strobe_w[0] && nlog0 < 64) begin log0[nlog0] = sx4(x_out_w[0]); nlog0++; end
      if (x_strobe_w[1] && nlog1 < 64) begin log1[nlog1] = sx4(x_out_w[1]); nlog1++; end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
   endtask

   // asserted between edges: outputs must clear before any clock edge
   task automatic do_reset();
      #2;
      rst = 1'b0;
      in_valid = 1'b0; coef_load = 1'b0; clr_underrun = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_x_out[%0d]", i),    int'(x_out_w[i]),    0);
         chk($sformatf("rst_a_out[%0d]", i),    int'(a_out_w[i]),    0);
         chk($sformatf("rst_fill[%0d]", i),     int'(fill_w[i]),     0);
         chk($sformatf("rst_in_ready[%0d]", i), int'(in_ready_w[i]), 1);
         chk($sformatf("rst_underrun[%0d]", i), int'(underrun_w[i]), 0);
         chk($sformatf("rst_x_strobe[%0d]", i), int'(x_strobe_w[i]), 0);
      end
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   logic [3:0] full_seq [5];
   int idx;

   initial begin
      mdiv[0] = 4; mdiv[1] = 1;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; coef_in = '0;
      coef_load = 1'b0; clr_underrun = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;

      // mid-burst reset with three samples buffered and non-zero outputs
      cyc(1'b0, 4'h0, 1'b1, 4'h5, 1'b0);
      idle(3);
      cyc(1'b1, 4'h3, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 4'h4, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 4'h5, 1'b0, 4'h0, 1'b0);
      chk("preburst_fill", int'(fill_w[0]), 3);
      chk("preburst_a_out", sx4(a_out_w[0]), 5);
      do_reset();

      // steady stream: 3,-2,7,1 then five ticks
      cyc(1'b1, 4'h3, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 4'hE, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 4'h7, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 4'h1, 1'b0, 4'h0, 1'b0);
      idle(12);
      chk("stream_underrun_before", int'(underrun_w[0]), 0);
      idle(4);
      chk("stream_underrun_after", int'(underrun_w[0]), 1);
      chk("stream_strobes", nlog0, 5);
      chk("stream_x0", log0[0], 3);
      chk("stream_x1", log0[1], -2);
      chk("stream_x2", log0[2], 7);
      chk("stream_x3", log0[3], 1);
      chk("stream_x4", log0[4], 0);
      chk("div1_x0", log1[0], 0);
      chk("div1_x1", log1[1], 3);
      chk("div1_x2", log1[2], -2);
      chk("div1_x3", log1[3], 7);
      chk("div1_x4", log1[4], 1);
      do_reset();

      // full: first push lands on a tick, then four more held back-to-back
      full_seq[0] = 4'h1; full_seq[1] = 4'h2; full_seq[2] = 4'h3;
      full_seq[3] = 4'h4; full_seq[4] = 4'h5;
      idle(3);
      idx = 0;
      while (idx < 5 && ecnt < 20) begin
         cyc(1'b1, full_seq[idx], 1'b0, 4'h0, 1'b0);
         if (macc[0] != 0) idx++;
         if (ecnt == 7) begin
            chk("full_fill7", int'(fill_w[0]), 4);
            chk("full_ready7", int'(in_ready_w[0]), 0);
         end
         if (ecnt == 8) chk("full_fill8", int'(fill_w[0]), 3);
         if (ecnt == 9) chk("full_fill9", int'(fill_w[0]), 4);
      end
      chk("full_accept_edge", ecnt, 9);
      idle(20);
      do_reset();

      // coefficient boundary behaviour
      cyc(1'b0, 4'h0, 1'b1, 4'h6, 1'b0);
      idle(2);
      chk("coef_before_tick", int'(a_out_w[0]), 0);
      idle(1);
      chk("coef_tick4", int'(a_out_w[0]), 6);
      idle(3);
      cyc(1'b0, 4'h0, 1'b1, 4'h3, 1'b0);
      chk("coef_tick8", int'(a_out_w[0]), 6);
      idle(4);
      chk("coef_tick12", int'(a_out_w[0]), 3);
      do_reset();

      // underrun clear racing a new underrun
      idle(3);
      cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      chk("clr_on_tick", int'(underrun_w[0]), 1);
      cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      chk("clr_off_tick", int'(underrun_w[0]), 0);
      do_reset();

      // randomized traffic with occasional mid-stream resets
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         cyc(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/iir_sample_feeder.md
Name: iir_sample_feeder

Overview:
- Upstream stage of the IIR filter. Accepts signed DATA_W-bit input samples over a valid/ready handshake and buffers them in a small FIFO.
- Issues exactly one sample to the filter every SAMPLE_DIV clocks on x_out/x_strobe.
- Presents the feedback coefficient on a_out. Coefficient updates are applied only at sample boundaries, so the filter never sees a coefficient change mid-sample.

Parameters:
- DATA_W, 4, sample/coefficient width (two's complement)
- DEPTH, 4, FIFO depth in samples; power of two, >= 2
- SAMPLE_DIV, 4, clocks per issued sample; >= 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- in_data  in  DATA_W  input sample
- in_valid  in  1  in_data valid
- in_ready  out  1  feeder can accept; combinational, = !full
- coef_in  in  DATA_W  new coefficient
- coef_load  in  1  capture coef_in into shadow register
- clr_underrun  in  1  clear sticky underrun flag
- x_out  out  DATA_W  sample to filter x input; registered
- a_out  out  DATA_W  coefficient to filter a input; registered
- x_strobe  out  1  one-cycle pulse, x_out updated this cycle
- underrun  out  1  sticky: a tick found the FIFO empty
- fill_level  out  $clog2(DEPTH+1)  samples currently buffered; registered

Behaviour:
- Reset (rst=0, async): FIFO empty, read/write pointers 0, fill_level=0, x_out=0, a_out=0, x_strobe=0, underrun=0, divider=0, shadow=0, pending=0, in_ready=1.
- Reset mid-operation discards buffered samples and any pending coefficient. Outputs return to reset values immediately, not at the next edge.
- Push: in_valid && in_ready at a rising edge writes in_data at wr_ptr; wr_ptr increments mod DEPTH.
- in_valid while full is ignored; the source must hold it.
- Divider: counts 0..SAMPLE_DIV-1 and wraps. tick = (divider == SAMPLE_DIV-1). With SAMPLE_DIV=1, tick is high every cycle.
- On tick with FIFO non-empty:
  - x_out <= FIFO head; rd_ptr increments mod DEPTH.
  - x_strobe <= 1 for that one cycle.
- On tick with FIFO empty:
  - x_out <= 0, x_strobe <= 1, underrun <= 1. Filter cadence is preserved by issuing a zero sample.
- x_strobe is 0 on all non-tick cycles; x_out holds its value between ticks.
- Push and pop in the same cycle: both performed, fill_level unchanged.
- Full FIFO: in_ready=0 even on a pop cycle. There is no same-cycle refill.
- Empty FIFO plus push on a tick: pop sees empty, so underrun fires. No bypass; the pushed sample issues at the next tick.
- Latency: a sample accepted at edge t reaches x_out at the first tick edge strictly after t (minimum 1 clock).
- Coefficient:
  - coef_load captures shadow <= coef_in and sets pending=1.
  - At a tick with pending=1, a_out <= shadow and pending is cleared.
  - coef_load on a tick cycle: that tick uses the old shadow/pending state. The new value applies at the following tick.
  - Back-to-back loads before a tick: last value wins.
- clr_underrun clears underrun. If it coincides with a new underrun event, set wins.
- fill_level tracks push/pop exactly: range 0..DEPTH, no wrap, never exceeds DEPTH.

Decomposition:
- Package iir_pkg holds:
  - DATA_W default
  - sample_t typedef (signed [DATA_W-1:0])
  - shared by this block, the IIR filter stage and the Baugh-Wooley multiplier.
- Sub-module sample_fifo:
  - Parameterized DATA_W/DEPTH synchronous FIFO: push, pop, full, empty, count, head.
  - Same async active-low rst.
- Divider, coefficient shadow and underrun logic stay in the top.

Test Plan (DATA_W=4, DEPTH=4, SAMPLE_DIV=4):
- Reset: assert rst=0 mid-burst with 3 samples buffered -> immediately x_out=0, a_out=0, fill_level=0, in_ready=1, underrun=0.
- Steady stream: push 3,-2,7,1, then 5 ticks -> x_out sequence 3,-2,7,1,0. x_strobe pulses exactly every 4 clocks. underrun=1 after 5th tick.
- Full: push 5 samples back-to-back with no tick -> in_ready=0 after 4th, 5th held off. fill_level=4; 5th accepted in the cycle after the next tick.
- Coefficient: coef_load 6 between ticks -> a_out=6 at the next tick edge. coef_load 3 on a tick cycle -> a_out stays 6 that tick, becomes 3 at the following tick.
- Underrun clear race: empty FIFO, clr_underrun=1 on a tick cycle -> underrun remains 1. clr_underrun on a non-tick cycle -> underrun=0.
- SAMPLE_DIV=1 build: push 1,2,3 one per cycle -> x_strobe continuous. x_out 0 (underrun), then 1,2,3 on successive cycles after each push.
